strassen_tile_seq: RTL and testbench

//  Start/done sequencer for the 7-ALU Strassen 2x2 multiplier datapath. Replaces the free-running

---
 rtl/strassen_tile_seq.sv | 183 ++++++++++++++++++
 tb/tb_strassen_tile_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/strassen_tile_seq.sv
// Start/done sequencer for the 7-ALU Strassen 2x2 datapath. It runs one gated four-phase pass
// for every (i,j,k) tile triple of a TILES x TILES block product, then pulses done.
module strassen_tile_seq #(
    parameter int TILES = 2,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] tile_i,
    output logic [IDX_W-1:0] tile_j,
    output logic [IDX_W-1:0] tile_k,
    output logic             acc_clr,
    output logic [1:0]       alu1,
    output logic [1:0]       alu2,
    output logic [1:0]       alu3,
    output logic [1:0]       alu4,
    output logic [1:0]       alu5,
    output logic [1:0]       alu6,
    output logic [1:0]       alu7,
    output logic             mux2,
    output logic [1:0]       mux3,
    output logic [1:0]       mux4,
    output logic             memWe,
    output logic             memMuxCtrl
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH0  = 3'd1,
        S_PH1  = 3'd2,
        S_PH2  = 3'd3,
        S_PH3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILES - 1);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] i_r, j_r, k_r;
    logic [IDX_W-1:0] i_s, j_s, k_s;

    // State and tile-index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            i_r     <= ZERO_IDX;
            j_r     <= ZERO_IDX;
            k_r     <= ZERO_IDX;
        end else begin
            state_r <= state_s;
            i_r     <= i_s;
            j_r     <= j_s;
            k_r     <= k_s;
        end
    end

    // Next state and index stepping; k is the fastest-moving index, i the slowest.
    always_comb begin
        state_s = state_r;
        i_s     = i_r;
        j_s     = j_r;
        k_s     = k_r;
        case (state_r)
            S_IDLE: begin
                if (start && !abort) begin
                    state_s = S_PH0;
                end else begin
                    state_s = S_IDLE;
                end
                i_s = ZERO_IDX;
                j_s = ZERO_IDX;
                k_s = ZERO_IDX;
            end
            S_PH0, S_PH1, S_PH2, S_PH3: begin
                if (abort) begin
                    state_s = S_IDLE;
                    i_s     = ZERO_IDX;
                    j_s     = ZERO_IDX;
                    k_s     = ZERO_IDX;
                end else if (state_r == S_PH0) begin
                    state_s = S_PH1;
                end else if (state_r == S_PH1) begin
                    state_s = S_PH2;
                end else if (state_r == S_PH2) begin
                    state_s = S_PH3;
                end else if (i_r == LAST_IDX && j_r == LAST_IDX && k_r == LAST_IDX) begin
                    state_s = S_DONE;
                    i_s     = ZERO_IDX;
                    j_s     = ZERO_IDX;
                    k_s     = ZERO_IDX;
                end else begin
                    state_s = S_PH0;
                    if (k_r == LAST_IDX) begin
                        k_s = ZERO_IDX;
                        if (j_r == LAST_IDX) begin
                            j_s = ZERO_IDX;
                            i_s = i_r + ONE_IDX;
                        end else begin
                            j_s = j_r + ONE_IDX;
                        end
                    end else begin
                        k_s = k_r + ONE_IDX;
                    end
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                i_s     = ZERO_IDX;
                j_s     = ZERO_IDX;
                k_s     = ZERO_IDX;
            end
        endcase
    end

    assign tile_i = i_r;
    assign tile_j = j_r;
    assign tile_k = k_r;

    // Moore decode of the phase into datapath controls; the first k pass overwrites the result.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        acc_clr    = 1'b0;
        {alu1, alu2, alu3, alu4, alu5, alu6, alu7} = 14'd0;
        mux2       = 1'b0;
        mux3       = 2'd0;
        mux4       = 2'd0;
        memWe      = 1'b0;
        memMuxCtrl = 1'b0;
        case (state_r)
            S_PH0: begin
                busy = 1'b1;
                {alu1, alu2, alu3, alu4, alu5, alu6, alu7} =
                    {2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
            end
            S_PH1: begin
                busy = 1'b1;
                mux2 = 1'b1;
                mux3 = 2'd1;
                mux4 = 2'd1;
                {alu1, alu2, alu3, alu4, alu5, alu6, alu7} =
                    {2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
            end
            S_PH2: begin
                busy    = 1'b1;
                mux2    = 1'b1;
                mux3    = 2'd2;
                mux4    = 2'd2;
                memWe   = 1'b1;
                acc_clr = (k_r == ZERO_IDX);
                {alu1, alu2, alu3, alu4, alu5, alu6, alu7} =
                    {2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
            end
            S_PH3: begin
                busy       = 1'b1;
                mux2       = 1'b1;
                mux3       = 2'd2;
                mux4       = 2'd3;
                memWe      = 1'b1;
                memMuxCtrl = 1'b1;
                acc_clr    = (k_r == ZERO_IDX);
                {alu1, alu2, alu3, alu4, alu5, alu6, alu7} =
                    {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_strassen_tile_seq.sv
// Bench for strassen_tile_seq: TILES=2 and TILES=1 instances checked every cycle against a
// model that derives the expected outputs from the number of cycles since a start was accepted.
module tb_strassen_tile_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start2, abort2, start1, abort1;

    logic       busy2, done2, acc2, m2_2, we2, mc2;
    logic [2:0] ti2, tj2, tk2;
    logic [1:0] a2 [7];
    logic [1:0] m3_2, m4_2;

    logic       busy1, done1, acc1, m2_1, we1, mc1;
    logic [2:0] ti1, tj1, tk1;
    logic [1:0] a1 [7];
    logic [1:0] m3_1, m4_1;

    strassen_tile_seq #(.TILES(2), .IDX_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .tile_i(ti2), .tile_j(tj2), .tile_k(tk2),
        .acc_clr(acc2), .alu1(a2[0]), .alu2(a2[1]), .alu3(a2[2]), .alu4(a2[3]),
        .alu5(a2[4]), .alu6(a2[5]), .alu7(a2[6]), .mux2(m2_2), .mux3(m3_2), .mux4(m4_2),
        .memWe(we2), .memMuxCtrl(mc2)
    );

    strassen_tile_seq #(.TILES(1), .IDX_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .tile_i(ti1), .tile_j(tj1), .tile_k(tk1),
        .acc_clr(acc1), .alu1(a1[0]), .alu2(a1[1]), .alu3(a1[2]), .alu4(a1[3]),
        .alu5(a1[4]), .alu6(a1[5]), .alu7(a1[6]), .mux2(m2_1), .mux3(m3_1), .mux4(m4_1),
        .memWe(we1), .memMuxCtrl(mc1)
    );

    logic [32:0] obs2, obs1;
    assign obs2 = {busy2, done2, ti2, tj2, tk2, acc2, a2[0], a2[1], a2[2], a2[3], a2[4],
                   a2[5], a2[6], m2_2, m3_2, m4_2, we2, mc2};
    assign obs1 = {busy1, done1, ti1, tj1, tk1, acc1, a1[0], a1[1], a1[2], a1[3], a1[4],
                   a1[5], a1[6], m2_1, m3_1, m4_1, we1, mc1};

    int tests = 0;
    int fails = 0;
    // run = 0 idle, 1..4*T^3 busy cycle number within the job, 4*T^3+1 the done cycle
    int run2 = 0;
    int run1 = 0;

    function automatic int mnext(int t, int run, logic s, logic a, logic r);
        int last;
        last = 4 * t * t * t;
        if (!r)                return 0;
        else if (run == 0)     return (s && !a) ? 1 : 0;
        else if (run > last)   return 0;
        else if (a)            return 0;
        else                   return run + 1;
    endfunction

    function automatic logic [32:0] exp_vec(int t, int run);
        int last, p, ph;
        logic [2:0]  ti, tj, tk;
        logic [13:0] alu;
        logic        m2, we, mc, acc;
        logic [1:0]  m3, m4;
        last = 4 * t * t * t;
        if (run == 0) return 33'd0;
        if (run > last) return {1'b0, 1'b1, 31'd0};
        p  = (run - 1) / 4;
        ph = (run - 1) % 4;
        tk = 3'(p % t);
        tj = 3'((p / t) % t);
        ti = 3'(p / (t * t));
        case (ph)
            0: begin alu = {2'd0,2'd0,2'd1,2'd1,2'd0,2'd1,2'd1}; m2=1'b0; m3=2'd0; m4=2'd0; we=1'b0; mc=1'b0; end
            1: begin alu = {2'd2,2'd2,2'd2,2'd2,2'd2,2'd2,2'd2}; m2=1'b1; m3=2'd1; m4=2'd1; we=1'b0; mc=1'b0; end
            2: begin alu = {2'd0,2'd1,2'd0,2'd0,2'd1,2'd0,2'd2}; m2=1'b1; m3=2'd2; m4=2'd2; we=1'b1; mc=1'b0; end
            default: begin alu = {2'd0,2'd0,2'd0,2'd0,2'd1,2'd0,2'd2}; m2=1'b1; m3=2'd2; m4=2'd3; we=1'b1; mc=1'b1; end
        endcase
        acc = we && (tk == 3'd0);
        return {1'b1, 1'b0, ti, tj, tk, acc, alu, m2, m3, m4, we, mc};
    endfunction

    task automatic advance();
        int n2, n1;
        n2 = mnext(2, run2, start2, abort2, rst_n);
        n1 = mnext(1, run1, start1, abort1, rst_n);
        @(posedge clk);
        #1;
        run2 = n2;
        run1 = n1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start2 = 1'b0; abort2 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        advance();
        advance();
        tests++;
        if (obs2 !== 33'd0) begin fails++; $display("FAIL reset_init2 got=%h exp=%h", obs2, 33'd0); end
        tests++;
        if (obs1 !== 33'd0) begin fails++; $display("FAIL reset_init1 got=%h exp=%h", obs1, 33'd0); end
        rst_n = 1'b1;
        start2 = 1'b1;
        advance();
        start2 = 1'b0;
        repeat (6) advance();
        tests++;
        if (busy2 !== 1'b1) begin fails++; $display("FAIL reset_prejob busy got=%b exp=1", busy2); end
        rst_n = 1'b0;
        advance();
        advance();
        rst_n = 1'b1;
        tests++;
        if (obs2 !== 33'd0) begin fails++; $display("FAIL reset_midjob got=%h exp=%h", obs2, 33'd0); end
        advance();
        tests++;
        if (obs2 !== exp_vec(2, run2)) begin fails++; $display("FAIL reset_after got=%h exp=%h", obs2, exp_vec(2, run2)); end
    endtask

    task automatic test_full_job();
        int busy_cnt;
        int done_at[$];
        busy_cnt = 0;
        for (int c = 0; c <= 70; c++) begin
            tests++;
            if (obs2 !== exp_vec(2, run2)) begin
                fails++; $display("FAIL full_job c=%0d got=%h exp=%h", c, obs2, exp_vec(2, run2));
            end
            if (busy2 === 1'b1) busy_cnt++;
            if (done2 === 1'b1) done_at.push_back(c);
            if (c == 0 || c == 5 || c == 33 || c == 34) start2 = 1'b1;
            else if (c >= 1 && c <= 32) start2 = 1'($urandom & 1);
            else start2 = 1'b0;
            abort2 = (c == 33) ? 1'b1 : 1'b0;
            advance();
        end
        start2 = 1'b0; abort2 = 1'b0;
        tests++;
        if (busy_cnt != 64) begin fails++; $display("FAIL full_job_busy_cycles got=%0d exp=64", busy_cnt); end
        tests++;
        if (done_at.size() != 2) begin
            fails++; $display("FAIL full_job_done_count got=%0d exp=2", done_at.size());
        end else begin
            tests++;
            if (done_at[0] != 33 || done_at[1] != 67) begin
                fails++; $display("FAIL full_job_done_cycles got=%0d,%0d exp=33,67", done_at[0], done_at[1]);
            end
        end
    endtask

    task automatic test_abort();
        int busy_cnt, done_cnt, abort_at;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c <= 47; c++) begin
            tests++;
            if (obs2 !== exp_vec(2, run2)) begin
                fails++; $display("FAIL abort c=%0d got=%h exp=%h", c, obs2, exp_vec(2, run2));
            end
            if (c == 11) begin
                tests++;
                if ({busy2, done2, ti2, tj2, tk2} !== 11'd0) begin
                    fails++; $display("FAIL abort_idle got=%h exp=%h", {busy2, done2, ti2, tj2, tk2}, 11'd0);
                end
            end
            if (c >= 12 && busy2 === 1'b1) busy_cnt++;
            if (done2 === 1'b1) done_cnt++;
            start2 = (c == 0 || c == 12) ? 1'b1 : 1'b0;
            abort2 = (c == 10) ? 1'b1 : 1'b0;
            advance();
        end
        start2 = 1'b0; abort2 = 1'b0;
        tests++;
        if (busy_cnt != 32 || done_cnt != 1) begin
            fails++; $display("FAIL abort_restart busy=%0d done=%0d exp busy=32 done=1", busy_cnt, done_cnt);
        end
        for (int n = 0; n < 4; n++) begin
            abort_at = int'($urandom_range(32, 1));
            done_cnt = 0;
            for (int c = 0; c <= abort_at + 3; c++) begin
                tests++;
                if (obs2 !== exp_vec(2, run2)) begin
                    fails++; $display("FAIL abort_rand a=%0d c=%0d got=%h exp=%h", abort_at, c, obs2, exp_vec(2, run2));
                end
                if (done2 === 1'b1) done_cnt++;
                start2 = (c == 0) ? 1'b1 : 1'b0;
                abort2 = (c == abort_at) ? 1'b1 : 1'b0;
                advance();
            end
            start2 = 1'b0; abort2 = 1'b0;
            tests++;
            if (done_cnt != 0) begin fails++; $display("FAIL abort_rand_done a=%0d got=%0d exp=0", abort_at, done_cnt); end
        end
    endtask

    task automatic test_start_abort_idle();
        start2 = 1'b1; abort2 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance();
            tests++;
            if (obs2 !== 33'd0) begin fails++; $display("FAIL start_abort_idle c=%0d got=%h exp=%h", c, obs2, 33'd0); end
        end
        start2 = 1'b0; abort2 = 1'b0;
        advance();
    endtask

    task automatic test_tiles1();
        for (int c = 0; c <= 8; c++) begin
            tests++;
            if (obs1 !== exp_vec(1, run1)) begin
                fails++; $display("FAIL tiles1 c=%0d got=%h exp=%h", c, obs1, exp_vec(1, run1));
            end
            tests++;
            if ({busy1, done1, acc1} !== {(c >= 1 && c <= 4), (c == 5), (c == 3 || c == 4)}) begin
                fails++; $display("FAIL tiles1_timing c=%0d got=%b exp=%b", c, {busy1, done1, acc1},
                                  {(c >= 1 && c <= 4), (c == 5), (c == 3 || c == 4)});
            end
            start1 = (c == 0 || c == 2) ? 1'b1 : 1'b0;
            abort1 = (c == 7) ? 1'b1 : 1'b0;
            advance();
        end
        start1 = 1'b0; abort1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_abort();
        test_start_abort_idle();
        test_tiles1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
